// File: rtl/sram_serial_burst_ctrl_if.sv
// Signal bundle for sram_serial_burst_ctrl: serial load, pointer control,
// read/write requests, status and serial read-back outputs.
interface sram_serial_burst_ctrl_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
);
  logic                  serial_in;
  logic                  shift;
  logic                  addr_load;
  logic [ADDR_WIDTH-1:0] addr_in;
  logic                  w_en;
  logic                  r_en;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  data_valid;
  logic                  busy;
  logic                  word_full;
  logic                  wr_err;
  logic [ADDR_WIDTH-1:0] ptr;
  logic                  sout;
  logic                  sout_valid;

  modport master (
    output serial_in, shift, addr_load, addr_in, w_en, r_en,
    input  data_out, data_valid, busy, word_full, wr_err, ptr, sout, sout_valid
  );

  modport slave (
    input  serial_in, shift, addr_load, addr_in, w_en, r_en,
    output data_out, data_valid, busy, word_full, wr_err, ptr, sout, sout_valid
  );
endinterface

// File: rtl/sram_serial_burst_ctrl.sv
// Serial-load register-array SRAM with an auto-incrementing pointer and registered reads.
// Define SRAM_SERIAL_READBACK_EN to add the MSB-first serial read-back path (sout/sout_valid).
module sram_serial_burst_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                    clk,
  input  logic                    arst_n,
  sram_serial_burst_ctrl_if.slave bus
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int CNT_W = $clog2(DATA_WIDTH + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DATA_WIDTH);

`ifdef SRAM_SERIAL_READBACK_EN
  typedef enum logic [1:0] {IDLE, RD, RDOUT, SOUT} state_t;
  localparam int SCNT_W = $clog2(DATA_WIDTH);
  localparam logic [SCNT_W-1:0] LAST_BIT = SCNT_W'(DATA_WIDTH - 1);
  logic [DATA_WIDTH-1:0] osr_q, osr_d;
  logic [SCNT_W-1:0]     sout_cnt_q, sout_cnt_d;
`else
  typedef enum logic [1:0] {IDLE, RD, RDOUT} state_t;
`endif

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] sreg_q, sreg_d;
  logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic [DATA_WIDTH-1:0] rd_q, rd_d;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic                  data_valid_q, data_valid_d;
  logic                  wr_err_q, wr_err_d;
  logic                  word_full;
  logic                  mem_we;
  logic                  ptr_inc;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  assign word_full = (bit_cnt_q == FULL_CNT);

  always_comb begin
    state_d      = state_q;
    sreg_d       = sreg_q;
    bit_cnt_d    = bit_cnt_q;
    ptr_d        = ptr_q;
    rd_d         = rd_q;
    data_out_d   = data_out_q;
    data_valid_d = 1'b0;
    wr_err_d     = 1'b0;
    mem_we       = 1'b0;
    ptr_inc      = 1'b0;
`ifdef SRAM_SERIAL_READBACK_EN
    osr_d        = osr_q;
    sout_cnt_d   = sout_cnt_q;
`endif

    if (bus.shift) begin
      sreg_d = {sreg_q[DATA_WIDTH-2:0], bus.serial_in};
      if (!word_full) bit_cnt_d = bit_cnt_q + 1'b1;
    end

    case (state_q)
      IDLE: begin
        // Write wins over a simultaneous read; a shift on the write edge starts the next word.
        if (bus.w_en) begin
          if (word_full) begin
            mem_we    = 1'b1;
            ptr_inc   = 1'b1;
            bit_cnt_d = bus.shift ? CNT_W'(1) : '0;
          end else begin
            wr_err_d = 1'b1;
          end
        end else if (bus.r_en) begin
          rd_d    = mem_q[ptr_q];
          ptr_inc = 1'b1;
          state_d = RD;
        end
      end
      RD: begin
        data_out_d   = rd_q;
        data_valid_d = 1'b1;
        state_d      = RDOUT;
      end
`ifdef SRAM_SERIAL_READBACK_EN
      RDOUT: begin
        osr_d      = data_out_q;
        sout_cnt_d = '0;
        state_d    = SOUT;
      end
      SOUT: begin
        osr_d      = {osr_q[DATA_WIDTH-2:0], 1'b0};
        sout_cnt_d = sout_cnt_q + 1'b1;
        if (sout_cnt_q == LAST_BIT) state_d = IDLE;
      end
`else
      RDOUT: state_d = IDLE;
`endif
      default: state_d = IDLE;
    endcase

    if (bus.addr_load)  ptr_d = bus.addr_in;
    else if (ptr_inc)   ptr_d = ptr_q + 1'b1;
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q      <= IDLE;
      sreg_q       <= '0;
      bit_cnt_q    <= '0;
      ptr_q        <= '0;
      rd_q         <= '0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      wr_err_q     <= 1'b0;
`ifdef SRAM_SERIAL_READBACK_EN
      osr_q        <= '0;
      sout_cnt_q   <= '0;
`endif
    end else begin
      state_q      <= state_d;
      sreg_q       <= sreg_d;
      bit_cnt_q    <= bit_cnt_d;
      ptr_q        <= ptr_d;
      rd_q         <= rd_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      wr_err_q     <= wr_err_d;
`ifdef SRAM_SERIAL_READBACK_EN
      osr_q        <= osr_d;
      sout_cnt_q   <= sout_cnt_d;
`endif
    end
  end

  // Array contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[ptr_q] <= sreg_q;
  end

  assign bus.data_out   = data_out_q;
  assign bus.data_valid = data_valid_q;
  assign bus.busy       = (state_q != IDLE);
  assign bus.word_full  = word_full;
  assign bus.wr_err     = wr_err_q;
  assign bus.ptr        = ptr_q;
`ifdef SRAM_SERIAL_READBACK_EN
  assign bus.sout       = (state_q == SOUT) & osr_q[DATA_WIDTH-1];
  assign bus.sout_valid = (state_q == SOUT);
`else
  assign bus.sout       = 1'b0;
  assign bus.sout_valid = 1'b0;
`endif
endmodule

// File: tb/tb_sram_serial_burst_ctrl.sv
// Bench for sram_serial_burst_ctrl: directed scenarios plus random traffic, every
// output compared each cycle against a timeline-based model of the controller.
module tb_sram_serial_burst_ctrl;
  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int DEPTH = 2 ** AW;
`ifdef SRAM_SERIAL_READBACK_EN
  localparam int BUSY_LEN = 2 + DW;
`else
  localparam int BUSY_LEN = 2;
`endif

  logic clk = 1'b0;
  logic arst_n = 1'b0;
  bit   check_en = 1'b0;
  int   n_cmp = 0;
  int   n_fail = 0;

  sram_serial_burst_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  sram_serial_burst_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk    (clk),
    .arst_n (arst_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  // Model: rd_age counts cycles since a read was accepted (-1 when no read in flight).
  logic [DW-1:0] m_sreg = '0;
  int            m_cnt = 0;
  int            m_ptr = 0;
  int            rd_age = -1;
  logic [DW-1:0] m_mem [DEPTH];
  bit            m_written [DEPTH];
  logic [DW-1:0] m_dout = '0;
  bit            m_dout_known = 1'b1;
  logic [DW-1:0] m_rd_word = '0;
  bit            m_rd_known = 1'b0;
  bit            m_wr_err = 1'b0;

  initial begin
    forever begin
      @(posedge clk or negedge arst_n);
      if (!arst_n) begin
        m_sreg = '0; m_cnt = 0; m_ptr = 0; rd_age = -1;
        m_dout = '0; m_dout_known = 1'b1; m_wr_err = 1'b0;
      end else begin
        automatic bit was_busy = (rd_age >= 0);
        automatic bit full = (m_cnt == DW);
        automatic int n_ptr = m_ptr;
        m_wr_err = 1'b0;
        if (!was_busy && bus.w_en) begin
          if (full) begin
            m_mem[m_ptr] = m_sreg;
            m_written[m_ptr] = 1'b1;
            n_ptr = (m_ptr + 1) % DEPTH;
            m_cnt = 0;
          end else begin
            m_wr_err = 1'b1;
          end
        end else if (!was_busy && bus.r_en) begin
          m_rd_word = m_mem[m_ptr];
          m_rd_known = m_written[m_ptr];
          n_ptr = (m_ptr + 1) % DEPTH;
        end
        if (bus.shift) begin
          m_sreg = {m_sreg[DW-2:0], bus.serial_in};
          if (m_cnt < DW) m_cnt = m_cnt + 1;
        end
        if (bus.addr_load) n_ptr = int'(bus.addr_in);
        m_ptr = n_ptr;
        if (rd_age >= 0) begin
          rd_age = rd_age + 1;
          if (rd_age >= BUSY_LEN) rd_age = -1;
        end
        if (!was_busy && !bus.w_en && bus.r_en) rd_age = 0;
        if (rd_age == 1) begin
          m_dout = m_rd_word;
          m_dout_known = m_rd_known;
        end
      end
    end
  end

  function automatic logic exp_sout_valid();
`ifdef SRAM_SERIAL_READBACK_EN
    return (rd_age >= 2);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic exp_sout();
`ifdef SRAM_SERIAL_READBACK_EN
    if (rd_age >= 2) return m_dout[DW-1-(rd_age-2)];
`endif
    return 1'b0;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      checkOutput("busy",       32'(bus.busy),       32'(rd_age >= 0));
      checkOutput("data_valid", 32'(bus.data_valid), 32'(rd_age == 1));
      checkOutput("word_full",  32'(bus.word_full),  32'(m_cnt == DW));
      checkOutput("wr_err",     32'(bus.wr_err),     32'(m_wr_err));
      checkOutput("ptr",        32'(bus.ptr),        32'(m_ptr));
      checkOutput("sout_valid", 32'(bus.sout_valid), 32'(exp_sout_valid()));
      checkOutput("sout",       32'(bus.sout),       32'(exp_sout()));
      if (m_dout_known) checkOutput("data_out", 32'(bus.data_out), 32'(m_dout));
    end
  end

  task automatic applyStimulus(input logic sh, input logic sin, input logic al,
                               input logic [AW-1:0] ai, input logic we, input logic re);
    bus.shift = sh; bus.serial_in = sin; bus.addr_load = al;
    bus.addr_in = ai; bus.w_en = we; bus.r_en = re;
    @(negedge clk);
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic loadPtr(input logic [AW-1:0] a);
    applyStimulus(1'b0, 1'b0, 1'b1, a, 1'b0, 1'b0);
  endtask

  task automatic shiftWord(input logic [DW-1:0] w);
    for (int i = DW - 1; i >= 0; i--) applyStimulus(1'b1, w[i], 1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic writeWord(input logic [DW-1:0] w);
    shiftWord(w);
    applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b0);
  endtask

  task automatic waitIdle();
    int n = 0;
    while (bus.busy === 1'b1 && n < 40) begin
      idleCycle();
      n++;
    end
    if (bus.busy !== 1'b0) begin
      n_cmp++; n_fail++;
      $display("[TB] FAIL busy_timeout: busy still 0x%0h after %0d cycles", bus.busy, n);
    end
  endtask

  task automatic readWord(input logic [DW-1:0] exp, input string name);
    bit seen = 1'b0;
    waitIdle();
    applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 20 && !seen; i++) begin
      idleCycle();
      if (bus.data_valid === 1'b1) seen = 1'b1;
    end
    if (seen) checkOutput(name, 32'(bus.data_out), 32'(exp));
    else begin
      n_cmp++; n_fail++;
      $display("[TB] FAIL %s: data_valid never seen, got 0x0 expected 0x1", name);
    end
    waitIdle();
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [11:0] pat;
    bus.shift = 1'b0; bus.serial_in = 1'b0; bus.addr_load = 1'b0;
    bus.addr_in = '0; bus.w_en = 1'b0; bus.r_en = 1'b0;
    arst_n = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst_data_out",   32'(bus.data_out),   0);
    checkOutput("rst_data_valid", 32'(bus.data_valid), 0);
    checkOutput("rst_busy",       32'(bus.busy),       0);
    checkOutput("rst_word_full",  32'(bus.word_full),  0);
    checkOutput("rst_wr_err",     32'(bus.wr_err),     0);
    checkOutput("rst_ptr",        32'(bus.ptr),        0);
    checkOutput("rst_sout",       32'(bus.sout),       0);
    checkOutput("rst_sout_valid", 32'(bus.sout_valid), 0);
    arst_n = 1'b1;
    check_en = 1'b1;

    $display("[TB] single write/read at address 3");
    loadPtr(3);
    shiftWord(8'hA5);
    checkOutput("t1_word_full", 32'(bus.word_full), 1);
    applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b0);
    checkOutput("t1_ptr_after_wr", 32'(bus.ptr), 4);
    checkOutput("t1_full_cleared", 32'(bus.word_full), 0);
    loadPtr(3);
    applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b1);
    checkOutput("t1_dv_early", 32'(bus.data_valid), 0);
    checkOutput("t1_busy", 32'(bus.busy), 1);
    idleCycle();
    checkOutput("t1_dv", 32'(bus.data_valid), 1);
    checkOutput("t1_data", 32'(bus.data_out), 'hA5);
    checkOutput("t1_ptr", 32'(bus.ptr), 4);
    waitIdle();

    $display("[TB] burst across the wrap point");
    loadPtr(14);
    writeWord(8'h11);
    writeWord(8'h22);
    writeWord(8'h33);
    checkOutput("t2_ptr_wrap", 32'(bus.ptr), 1);
    loadPtr(14);
    readWord(8'h11, "t2_rd0");
    readWord(8'h22, "t2_rd1");
    readWord(8'h33, "t2_rd2");
    checkOutput("t2_ptr_end", 32'(bus.ptr), 1);

    $display("[TB] short word write rejected");
    loadPtr(14);
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b1, 1'b0, '0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b0);
    checkOutput("t3_wr_err", 32'(bus.wr_err), 1);
    checkOutput("t3_ptr", 32'(bus.ptr), 14);
    idleCycle();
    checkOutput("t3_wr_err_pulse", 32'(bus.wr_err), 0);
    readWord(8'h11, "t3_mem_kept");

    $display("[TB] requests while busy, then simultaneous w_en/r_en");
    shiftWord(8'h5C);
    applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b1);
    checkOutput("t4_ptr_rd", 32'(bus.ptr), 0);
    applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b0);
    checkOutput("t4_dv", 32'(bus.data_valid), 1);
    checkOutput("t4_data", 32'(bus.data_out), 'h22);
    applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b1);
    checkOutput("t4_no_wr_err", 32'(bus.wr_err), 0);
    checkOutput("t4_ptr_hold", 32'(bus.ptr), 0);
    checkOutput("t4_word_full", 32'(bus.word_full), 1);
    waitIdle();
    applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b1);
    checkOutput("t4_both_ptr", 32'(bus.ptr), 1);
    checkOutput("t4_both_busy", 32'(bus.busy), 0);
    idleCycle();
    idleCycle();
    checkOutput("t4_both_no_dv", 32'(bus.data_valid), 0);
    loadPtr(0);
    readWord(8'h5C, "t4_both_written");

    $display("[TB] over-shifted word keeps the last bits");
    loadPtr(5);
    pat = 12'b1111_0000_1010;
    for (int i = 11; i >= 0; i--) applyStimulus(1'b1, pat[i], 1'b0, '0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b0);
    loadPtr(5);
    readWord(8'h0A, "t5_last_bits");

    $display("[TB] read of 0xC3 and read-back");
    loadPtr(6);
    writeWord(8'hC3);
    loadPtr(6);
    applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b1);
    idleCycle();
    checkOutput("t6_dv", 32'(bus.data_valid), 1);
    checkOutput("t6_data", 32'(bus.data_out), 'hC3);
`ifdef SRAM_SERIAL_READBACK_EN
    for (int i = DW - 1; i >= 0; i--) begin
      logic [DW-1:0] c3;
      c3 = 8'hC3;
      idleCycle();
      checkOutput("t6_sout", 32'(bus.sout), 32'(c3[i]));
      checkOutput("t6_sout_valid", 32'(bus.sout_valid), 1);
      checkOutput("t6_busy_sout", 32'(bus.busy), 1);
    end
`endif
    idleCycle();
    checkOutput("t6_busy_done", 32'(bus.busy), 0);
    checkOutput("t6_sout_valid_done", 32'(bus.sout_valid), 0);

    $display("[TB] reset in the middle of a read");
    loadPtr(6);
    applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b1);
    #1 arst_n = 1'b0;
    @(negedge clk);
    checkOutput("t7_busy", 32'(bus.busy), 0);
    checkOutput("t7_data", 32'(bus.data_out), 0);
    checkOutput("t7_ptr", 32'(bus.ptr), 0);
    arst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      idleCycle();
      checkOutput("t7_no_dv", 32'(bus.data_valid), 0);
    end

    $display("[TB] random traffic");
    loadPtr(0);
    for (int i = 0; i < DEPTH; i++) writeWord(DW'($urandom));
    for (int c = 0; c < 1500; c++) begin
      applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    ($urandom_range(0, 15) == 0), AW'($urandom_range(0, DEPTH - 1)),
                    ($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0));
    end
    waitIdle();
    idleCycle();

    check_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
